// File: rtl/bitwise_nor_4bit.sv
// 4-bit bitwise NOR slice: a gate-level combinational result for the ALU mux,
// plus an enable-gated registered copy with a valid flag for pipelined consumers.
`timescale 1ns/1ps
module bitwise_nor_4bit (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_op1,
    input  logic [3:0] i_op2,
    input  logic       i_en,
    output logic [3:0] o_dat,
    output logic [3:0] o_dat_q,
    output logic       o_vld_q
);

    wire  [3:0] nor_w;
    logic [3:0] dat_d;
    logic [3:0] dat_q;
    logic       vld_d;
    logic       vld_q;

    // One 2-input nor primitive per bit; this path never sees clock, reset or enable.
    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_nor
            nor u_nor (nor_w[k], i_op1[k], i_op2[k]);
        end
    endgenerate

    assign o_dat = nor_w;

    // Enable is a hold mux in front of D; the clock itself is never gated.
    always_comb begin
        dat_d = dat_q;
        vld_d = vld_q;
        if (i_en) begin
            dat_d = nor_w;
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dat_q <= 4'b0000;
            vld_q <= 1'b0;
        end else begin
            dat_q <= dat_d;
            vld_q <= vld_d;
        end
    end

    assign o_dat_q = dat_q;
    assign o_vld_q = vld_q;

endmodule

// File: tb/tb_bitwise_nor_4bit.sv
// Directed bench for bitwise_nor_4bit: exhaustive combinational sweep, corner
// vectors, reset/capture/hold, async mid-cycle reset and back-to-back captures.
`timescale 1ns/1ps
module tb_bitwise_nor_4bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] op1;
    logic [3:0] op2;
    logic       en;
    logic [3:0] o_dat;
    logic [3:0] o_dat_q;
    logic       o_vld_q;

    int errors = 0;
    int checks = 0;

    // Reference register state, updated from the operation rules.
    logic [3:0] m_dat = 4'h0;
    logic       m_vld = 1'b0;
    logic [3:0] exp_q[$];

    bitwise_nor_4bit dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_op1   (op1),
        .i_op2   (op2),
        .i_en    (en),
        .o_dat   (o_dat),
        .o_dat_q (o_dat_q),
        .o_vld_q (o_vld_q)
    );

    // Clock: rising edges at 5, 15, 25 ...; falling edges at 10, 20, ...
    always #5 clk = ~clk;

    // NOR of two 4-bit values equals 15 minus their OR.
    function automatic logic [3:0] nor_ref(input int a, input int b);
        int r;
        r = 15 - (a | b);
        return r[3:0];
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n === 1'b1 && en === 1'b1) begin
            m_dat = nor_ref(int'(op1), int'(op2));
            m_vld = 1'b1;
        end
    end

    always @(negedge rst_n) begin
        m_dat = 4'h0;
        m_vld = 1'b0;
    end

    // Compare process: every falling edge + 1 ns, away from stimulus changes.
    always @(negedge clk) begin
        #1;
        chk("cyc_o_dat", o_dat, nor_ref(int'(op1), int'(op2)));
        chk("cyc_o_dat_q", o_dat_q, m_dat);
        chk("cyc_o_vld_q", {3'b000, o_vld_q}, {3'b000, m_vld});
    end

    logic [3:0] c_a [6] = '{4'h0, 4'hF, 4'h0, 4'h5, 4'h3, 4'hC};
    logic [3:0] c_b [6] = '{4'h0, 4'h0, 4'hF, 4'hA, 4'h4, 4'hC};
    logic [3:0] c_e [6] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h8, 4'h3};
    logic [3:0] b_a [3] = '{4'h0, 4'h1, 4'hF};
    logic [3:0] b_b [3] = '{4'h0, 4'h2, 4'hF};

    initial begin
        rst_n = 1'b1;
        en    = 1'b1;
        op1   = 4'h0;
        op2   = 4'h0;
        #1 rst_n = 1'b0;

        // Reset held for 3 cycles with enable high.
        repeat (3) begin
            @(negedge clk); #2;
            chk("rst_dat_q", o_dat_q, 4'h0);
            chk("rst_vld_q", {3'b000, o_vld_q}, 4'h0);
            chk("rst_o_dat", o_dat, 4'hF);
        end

        // Release and capture (3,4).
        rst_n = 1'b1;
        op1 = 4'h3; op2 = 4'h4; en = 1'b1;
        @(negedge clk); #2;
        chk("cap_dat_q", o_dat_q, 4'h8);
        chk("cap_vld_q", {3'b000, o_vld_q}, 4'h1);

        // Hold with enable low while operands change.
        en = 1'b0; op1 = 4'h0; op2 = 4'h0;
        repeat (2) begin
            @(negedge clk); #2;
            chk("hold_dat_q", o_dat_q, 4'h8);
            chk("hold_vld_q", {3'b000, o_vld_q}, 4'h1);
            chk("hold_o_dat", o_dat, 4'hF);
        end

        // 2 ns async reset pulse between edges.
        rst_n = 1'b0;
        #1;
        chk("arst_dat_q", o_dat_q, 4'h0);
        chk("arst_vld_q", {3'b000, o_vld_q}, 4'h0);
        chk("arst_o_dat", o_dat, 4'hF);
        #1 rst_n = 1'b1;

        // Exhaustive sweep, 1 ns per vector, off the integer clock grid.
        @(negedge clk); #0.5;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                op1 = 4'(a); op2 = 4'(b);
                #1;
                chk("sweep", o_dat, nor_ref(a, b));
            end
        end

        // Corner vectors with hand-computed results.
        @(negedge clk); #2;
        for (int i = 0; i < 6; i++) begin
            op1 = c_a[i]; op2 = c_b[i];
            #0.5;
            chk("corner", o_dat, c_e[i]);
        end
        chk("corner_hold_q", o_dat_q, 4'h0);

        // Back-to-back captures: F, C, 0 one edge after each is applied.
        @(negedge clk); #2;
        en = 1'b1;
        exp_q.push_back(4'hF);
        exp_q.push_back(4'hC);
        exp_q.push_back(4'h0);
        for (int i = 0; i < 3; i++) begin
            op1 = b_a[i]; op2 = b_b[i];
            @(negedge clk); #2;
            chk("b2b_dat_q", o_dat_q, exp_q.pop_front());
            chk("b2b_vld_q", {3'b000, o_vld_q}, 4'h1);
        end
        en = 1'b0;

        @(negedge clk); #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
